// File: rtl/display_multiplexer.sv
// Binary-to-BCD 4-digit multiplexed common-anode 7-segment driver.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module display_multiplexer #(
    parameter int unsigned DIGIT_CYCLES = 100_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] sum_result,
    output logic [6:0]  segments,
    output logic [3:0]  display_select
);

    localparam int unsigned CntW = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIGIT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      thousands_q, hundreds_q, tens_q, units_q;
    logic [27:0]     shift;
    logic [6:0]      segments_q, segments_d;
    logic [3:0]      select_q, select_d;
    logic [3:0]      digit;
    logic            blank_thousands, blank_hundreds, blank_tens, blank;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Double-dabble: BCD digits accumulate in shift[27:12] over 12 shifts.
    always_comb begin
        shift = {16'd0, sum_result};
        for (int i = 0; i < 12; i++) begin
            for (int d = 0; d < 4; d++) begin
                if (shift[12+4*d +: 4] >= 4'd5) begin
                    shift[12+4*d +: 4] = shift[12+4*d +: 4] + 4'd3;
                end
            end
            shift = shift << 1;
        end
    end

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        idx_d = idx_q;
        if (cnt_q == CntMax) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        blank_thousands = (thousands_q == 4'd0);
        blank_hundreds  = blank_thousands && (hundreds_q == 4'd0);
        blank_tens      = blank_hundreds && (tens_q == 4'd0);
`else
        blank_thousands = 1'b0;
        blank_hundreds  = 1'b0;
        blank_tens      = 1'b0;
`endif
    end

    // Outputs follow the next index so display_select always matches idx_q.
    always_comb begin
        digit    = units_q;
        select_d = 4'b1110;
        blank    = 1'b0;
        unique case (idx_d)
            2'd0: begin
                digit    = units_q;
                select_d = 4'b1110;
                blank    = 1'b0;
            end
            2'd1: begin
                digit    = tens_q;
                select_d = 4'b1101;
                blank    = blank_tens;
            end
            2'd2: begin
                digit    = hundreds_q;
                select_d = 4'b1011;
                blank    = blank_hundreds;
            end
            2'd3: begin
                digit    = thousands_q;
                select_d = 4'b0111;
                blank    = blank_thousands;
            end
        endcase
        segments_d = blank ? 7'b1111111 : seg_encode(digit);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            thousands_q <= 4'd0;
            hundreds_q  <= 4'd0;
            tens_q      <= 4'd0;
            units_q     <= 4'd0;
            segments_q  <= 7'b1000000;
            select_q    <= 4'b1110;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            thousands_q <= shift[27:24];
            hundreds_q  <= shift[23:20];
            tens_q      <= shift[19:16];
            units_q     <= shift[15:12];
            segments_q  <= segments_d;
            select_q    <= select_d;
        end
    end

    assign segments       = segments_q;
    assign display_select = select_q;

endmodule

// File: tb/tb_display_multiplexer.sv
// Directed self-checking bench for display_multiplexer with DIGIT_CYCLES=4.
module tb_display_multiplexer;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] sum_result;
    logic [6:0]  segments;
    logic [3:0]  display_select;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'b1111111;
`else
    localparam logic [6:0] LZ = 7'b1000000;
`endif

    logic [3:0] anode_map [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    display_multiplexer #(.DIGIT_CYCLES(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .sum_result     (sum_result),
        .segments       (segments),
        .display_select (display_select)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        checks++;
        assert ($onehot(~display_select)) else begin
            errors++;
            $error("FAIL onehot_zero observed %b expected exactly one low bit", display_select);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for a fresh units phase, then checks each anode phase in order.
    task automatic scan_check(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
        logic [3:0] prev;
        logic [6:0] exp_seg [4];
        int n;
        exp_seg = '{e0, e1, e2, e3};
        repeat (2) @(negedge clk);
        n = 0;
        prev = display_select;
        @(negedge clk);
        while (!(display_select == 4'b1110 && prev != 4'b1110) && n < 40) begin
            prev = display_select;
            @(negedge clk);
            n++;
        end
        chk({tag, "_sync_timeout"}, 32'(n < 40), 32'd1);
        for (int p = 0; p < 4; p++) begin
            chk({tag, "_sel"}, 32'(display_select), 32'(anode_map[p]));
            chk({tag, "_seg"}, 32'(segments), 32'(exp_seg[p]));
            repeat (4) @(negedge clk);
        end
    endtask

    initial begin
        int n;
        reset      = 1'b0;
        sum_result = 12'd0;
        repeat (3) @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            chk("reset_sel", 32'(display_select), 32'h0000000e);
            chk("reset_seg", 32'(segments), 32'(S0));
            @(negedge clk);
        end
        chk("reset_bcd", {16'd0, dut.thousands_q, dut.hundreds_q, dut.tens_q, dut.units_q}, 32'd0);

        reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            chk("scan_sel", 32'(display_select), 32'(anode_map[(k / 4) % 4]));
            chk("scan_seg", 32'(segments), 32'((((k / 4) % 4) == 0) ? S0 : LZ));
            @(negedge clk);
        end

        sum_result = 12'd1998;
        chk("bcd_latency_old", 32'(dut.units_q), 32'd0);
        @(posedge clk);
        #1;
        chk("bcd_1998", {16'd0, dut.thousands_q, dut.hundreds_q, dut.tens_q, dut.units_q},
            32'h00001998);
        scan_check("v1998", S8, S9, S9, S1);

        sum_result = 12'd930;
        scan_check("v930", S0, S3, S9, LZ);

        sum_result = 12'd4095;
        scan_check("v4095", S5, S9, S0, S4);
        chk("bcd_4095", {16'd0, dut.thousands_q, dut.hundreds_q, dut.tens_q, dut.units_q},
            32'h00004095);

        sum_result = 12'd5;
        scan_check("v5", S5, LZ, LZ, LZ);

        n = 0;
        while (display_select != 4'b1011 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("midscan_sync_timeout", 32'(n < 40), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_sel", 32'(display_select), 32'h0000000e);
        chk("async_reset_seg", 32'(segments), 32'(S0));
        chk("async_reset_bcd", 32'(dut.units_q), 32'd0);
        repeat (3) @(negedge clk);
        chk("held_reset_sel", 32'(display_select), 32'h0000000e);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("restart_sel", 32'(display_select), 32'((k < 4) ? 4'b1110 : 4'b1101));
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
